multicycle_sequencer: RTL and testbench

- Multi-cycle control sequencer for the processor core.
- Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Owns the program counter and gates the combinational decoder's Branch / Write_Reg / Mem_Write outputs into one-cycle enables.
- Sits between instruction memory, the decoder, the register file and data memory; handles halt, data-memory wait states and a memory-timeout error.

---
 rtl/multicycle_sequencer_pkg.sv | 22 ++
 rtl/multicycle_sequencer_if.sv | 56 +++++
 rtl/multicycle_sequencer_pc_unit.sv | 31 +++
 rtl/multicycle_sequencer.sv | 134 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle control sequencer.
//   state_t         : 3-bit sequencer state, also exported on the debug State port
//   PC_W_DEF        : default program counter width
//   MEM_TIMEOUT_DEF : default MEM-state wait limit before the error trap
package seq_pkg;

   localparam int unsigned PC_W_DEF        = 10;
   localparam int unsigned MEM_TIMEOUT_DEF = 16;
   localparam int unsigned WAIT_CNT_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings: the instruction
// decoder, ALU branch result, data memory, register file and instruction register.
//   master : the sequencer side (drives PC, enables, Done, Error, State)
//   slave  : the environment side (drives Start, decoder flags, Taken/Target, Mem_Ready)
// With SEQ_PERF_CNT_EN defined, the bundle also carries Cycle_Cnt and Instr_Cnt.
interface multicycle_sequencer_if #(
   parameter int unsigned PC_W = seq_pkg::PC_W_DEF
);
   logic            Start;
   logic            Branch;
   logic            Write_Reg;
   logic            Mem_Write;
   logic            Mem_Read;
   logic            Halt_Instr;
   logic            Taken;
   logic [PC_W-1:0] Target;
   logic            Mem_Ready;
   logic [PC_W-1:0] PC;
   logic            Instr_Load;
   logic            Reg_Write_En;
   logic            Mem_Write_En;
   logic            Mem_Read_En;
   logic            Done;
   logic            Error;
   logic [2:0]      State;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]     Cycle_Cnt;
   logic [31:0]     Instr_Cnt;

   modport master (
      input  Start, Branch, Write_Reg, Mem_Write, Mem_Read, Halt_Instr,
             Taken, Target, Mem_Ready,
      output PC, Instr_Load, Reg_Write_En, Mem_Write_En, Mem_Read_En,
             Done, Error, State, Cycle_Cnt, Instr_Cnt
   );
   modport slave (
      output Start, Branch, Write_Reg, Mem_Write, Mem_Read, Halt_Instr,
             Taken, Target, Mem_Ready,
      input  PC, Instr_Load, Reg_Write_En, Mem_Write_En, Mem_Read_En,
             Done, Error, State, Cycle_Cnt, Instr_Cnt
   );
`else
   modport master (
      input  Start, Branch, Write_Reg, Mem_Write, Mem_Read, Halt_Instr,
             Taken, Target, Mem_Ready,
      output PC, Instr_Load, Reg_Write_En, Mem_Write_En, Mem_Read_En,
             Done, Error, State
   );
   modport slave (
      output Start, Branch, Write_Reg, Mem_Write, Mem_Read, Halt_Instr,
             Taken, Target, Mem_Ready,
      input  PC, Instr_Load, Reg_Write_En, Mem_Write_En, Mem_Read_En,
             Done, Error, State
   );
`endif
endinterface

// File: rtl/multicycle_sequencer_pc_unit.sv
// Program counter register with clear / load / increment.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : force PC to 0 (highest priority)
//   load       : take target (taken branch)
//   inc        : PC + 1, wrapping modulo 2^PC_W
//   pc         : current program counter
module pc_unit #(
   parameter int unsigned PC_W = seq_pkg::PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (clr) begin
         pc <= '0;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, owns the PC and turns the decoder's
// level flags into one-cycle enables. Handles halt, memory wait states and a
// sticky memory-timeout trap (left only through reset).
//   Clk, Reset_n : clock and asynchronous active-low reset
//   bus          : multicycle_sequencer_if.master (decoder / memory / regfile signals)
// Optional macro SEQ_PERF_CNT_EN adds saturating Cycle_Cnt / Instr_Cnt counters.
module multicycle_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   multicycle_sequencer_if.master bus
);

   localparam logic [WAIT_CNT_W-1:0] TMO_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   state_t                  state, state_nxt;
   logic                    f_br, f_wr, f_mw, f_mr, f_tk;
   logic [PC_W-1:0]         tgt_q;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   logic                    il_q, rw_q, mw_q, mr_q, done_q, err_q;
   logic                    start_acc, pc_load, pc_inc;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.Start) state_nxt = ST_FETCH;
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = bus.Halt_Instr ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_nxt = (f_mw || f_mr) ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (bus.Mem_Ready)           state_nxt = ST_WB;
            else if (wait_cnt == TMO_LAST) state_nxt = ST_ERR;
         end
         ST_WB:     state_nxt = ST_FETCH;
         ST_HALT:   if (bus.Start) state_nxt = ST_FETCH;
         ST_ERR:    state_nxt = ST_ERR;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign start_acc = bus.Start && (state == ST_IDLE || state == ST_HALT);
   assign pc_load   = (state == ST_WB) && f_br && f_tk;
   assign pc_inc    = (state == ST_WB) && !pc_load;

   // State, flag latches, wait counter; outputs registered from the next state
   // so they line up with the state they belong to.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         f_br     <= 1'b0;
         f_wr     <= 1'b0;
         f_mw     <= 1'b0;
         f_mr     <= 1'b0;
         f_tk     <= 1'b0;
         tgt_q    <= '0;
         wait_cnt <= '0;
         il_q     <= 1'b0;
         rw_q     <= 1'b0;
         mw_q     <= 1'b0;
         mr_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_DECODE) begin
            f_br <= bus.Branch;
            f_wr <= bus.Write_Reg;
            f_mw <= bus.Mem_Write;
            f_mr <= bus.Mem_Read;
         end
         if (state == ST_EXEC) begin
            f_tk  <= bus.Taken;
            tgt_q <= bus.Target;
         end
         // Zero outside MEM, so every MEM visit starts counting from 0
         wait_cnt <= (state == ST_MEM) ? wait_cnt + WAIT_CNT_W'(1) : '0;
         il_q   <= (state_nxt == ST_FETCH);
         rw_q   <= (state_nxt == ST_WB) && f_wr;
         mw_q   <= (state_nxt == ST_MEM) && f_mw;
         mr_q   <= (state_nxt == ST_MEM) && f_mr && !f_mw;
         done_q <= (state_nxt == ST_HALT);
         err_q  <= (state_nxt == ST_ERR);
      end
   end

   pc_unit #(.PC_W(PC_W)) u_pc (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .clr    (start_acc),
      .load   (pc_load),
      .inc    (pc_inc),
      .target (tgt_q),
      .pc     (bus.PC)
   );

   assign bus.Instr_Load   = il_q;
   assign bus.Reg_Write_En = rw_q;
   assign bus.Mem_Write_En = mw_q;
   assign bus.Mem_Read_En  = mr_q;
   assign bus.Done         = done_q;
   assign bus.Error        = err_q;
   assign bus.State        = state;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
   logic        active;

   assign active = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERR);

   // Saturating performance counters, cleared by an accepted Start
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else if (start_acc) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (active && cycle_cnt != '1)            cycle_cnt <= cycle_cnt + 32'd1;
         if (state == ST_WB && instr_cnt != '1)    instr_cnt <= instr_cnt + 32'd1;
      end
   end

   assign bus.Cycle_Cnt = cycle_cnt;
   assign bus.Instr_Cnt = instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a table of single instructions
// (flags, branch data, memory wait) with hand-computed latency, enable counts
// and resulting PC, plus hand-written reset, timeout and halt sequences.
module tb_multicycle_sequencer;
   import seq_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   multicycle_sequencer_if #(.PC_W(10)) bus ();

   multicycle_sequencer #(.PC_W(10), .MEM_TIMEOUT(16)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       br, wr, mw, mr, tk;
      logic [9:0] tgt;
      int         wait_n;
      int         e_lat, e_rw, e_mr, e_mw;
      logic [9:0] e_pc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.Start = 0; bus.Branch = 0; bus.Write_Reg = 0; bus.Mem_Write = 0;
      bus.Mem_Read = 0; bus.Halt_Instr = 0; bus.Taken = 0; bus.Target = '0;
      bus.Mem_Ready = 0;
   endtask

   // Entered at a negedge with State==FETCH; returns at the next FETCH (or after 40 cycles).
   task automatic run_instr(input vec_t v, output int lat, output int il, output int rw,
                            output int rw_at, output int mr, output int mw, output int flg);
      int memc;
      lat = 0; il = 0; rw = 0; rw_at = 0; mr = 0; mw = 0; flg = 0; memc = 0;
      bus.Branch = v.br; bus.Write_Reg = v.wr; bus.Mem_Write = v.mw; bus.Mem_Read = v.mr;
      bus.Halt_Instr = 0; bus.Taken = v.tk; bus.Target = v.tgt;
      for (int c = 0; c < 40; c++) begin
         lat++;
         if (bus.Instr_Load) il++;
         if (bus.Reg_Write_En) begin rw++; rw_at = lat; end
         if (bus.Mem_Read_En) mr++;
         if (bus.Mem_Write_En) mw++;
         if (bus.Done || bus.Error) flg++;
         if (bus.State == 3'd4) begin
            memc++;
            bus.Mem_Ready = (memc == v.wait_n + 1);
         end else begin
            bus.Mem_Ready = 0;
         end
         @(posedge Clk); @(negedge Clk);
         if (bus.State == 3'd1) break;
      end
      bus.Mem_Ready = 0;
   endtask

   task automatic pulse_start();
      bus.Start = 1;
      @(negedge Clk);
      bus.Start = 0;
   endtask

   initial begin
      int lat, il, rw, rw_at, mr, mw, flg, memc, mwc;
      vec_t alu;

      //        br wr mw mr tk tgt     w   lat rw mr mw pc
      vecs[0] = '{0, 1, 0, 0, 0, 10'h000, 0,   4, 1, 0, 0, 10'h001};
      vecs[1] = '{0, 1, 0, 1, 0, 10'h000, 3,   8, 1, 4, 0, 10'h002};
      vecs[2] = '{0, 0, 1, 0, 0, 10'h000, 0,   5, 0, 0, 1, 10'h003};
      vecs[3] = '{0, 0, 1, 1, 0, 10'h000, 1,   6, 0, 0, 2, 10'h004};
      vecs[4] = '{1, 0, 0, 0, 1, 10'h3A0, 0,   4, 0, 0, 0, 10'h3A0};
      vecs[5] = '{1, 0, 0, 0, 0, 10'h010, 0,   4, 0, 0, 0, 10'h3A1};
      vecs[6] = '{1, 0, 0, 0, 1, 10'h3FF, 0,   4, 0, 0, 0, 10'h3FF};
      vecs[7] = '{1, 0, 0, 0, 0, 10'h123, 0,   4, 0, 0, 0, 10'h000};
      vecs[8] = '{0, 0, 0, 0, 1, 10'h055, 0,   4, 0, 0, 0, 10'h001};
      vecs[9] = '{0, 1, 0, 1, 0, 10'h000, 15, 20, 1, 16, 0, 10'h002};

      clear_inputs();
      #12;
      chk("rst_state", 32'(bus.State), 32'd0);
      chk("rst_pc", 32'(bus.PC), 32'd0);
      chk("rst_outs", {26'd0, bus.Instr_Load, bus.Reg_Write_En, bus.Mem_Write_En,
                       bus.Mem_Read_En, bus.Done, bus.Error}, 32'd0);
      @(negedge Clk);
      Reset_n = 1;
      @(negedge Clk);
      chk("idle_hold", 32'(bus.State), 32'd0);
      pulse_start();
      chk("start_fetch", 32'(bus.State), 32'd1);

      // Table of single instructions
      for (int i = 0; i < 10; i++) begin
         run_instr(vecs[i], lat, il, rw, rw_at, mr, mw, flg);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].e_lat));
         chk($sformatf("v%0d_il", i), 32'(il), 32'd1);
         chk($sformatf("v%0d_rw", i), 32'(rw), 32'(vecs[i].e_rw));
         if (vecs[i].e_rw != 0) chk($sformatf("v%0d_rw_at", i), 32'(rw_at), 32'(vecs[i].e_lat));
         chk($sformatf("v%0d_mr", i), 32'(mr), 32'(vecs[i].e_mr));
         chk($sformatf("v%0d_mw", i), 32'(mw), 32'(vecs[i].e_mw));
         chk($sformatf("v%0d_flags", i), 32'(flg), 32'd0);
         chk($sformatf("v%0d_pc", i), 32'(bus.PC), 32'(vecs[i].e_pc));
         chk($sformatf("v%0d_fetch", i), 32'(bus.State), 32'd1);
      end

      // Reset in the middle of EXEC
      bus.Write_Reg = 1;
      @(negedge Clk); @(negedge Clk);
      chk("mid_exec", 32'(bus.State), 32'd3);
      #1 Reset_n = 0;
      #1;
      chk("midrst_state", 32'(bus.State), 32'd0);
      chk("midrst_pc", 32'(bus.PC), 32'd0);
      chk("midrst_outs", {26'd0, bus.Instr_Load, bus.Reg_Write_En, bus.Mem_Write_En,
                          bus.Mem_Read_En, bus.Done, bus.Error}, 32'd0);
      clear_inputs();
      @(negedge Clk);
      Reset_n = 1;
      @(negedge Clk);

      // Store that never gets Mem_Ready -> error trap
      pulse_start();
      bus.Mem_Write = 1;
      memc = 0; mwc = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.State == 3'd4) memc++;
         if (bus.Mem_Write_En) mwc++;
         if (bus.State == 3'd7) break;
         @(posedge Clk); @(negedge Clk);
      end
      chk("tmo_mem_cycles", 32'(memc), 32'd16);
      chk("tmo_mw_cycles", 32'(mwc), 32'd16);
      chk("tmo_state", 32'(bus.State), 32'd7);
      chk("tmo_error", 32'(bus.Error), 32'd1);
      chk("tmo_mw_off", 32'(bus.Mem_Write_En), 32'd0);
      bus.Start = 1;
      repeat (3) @(negedge Clk);
      bus.Start = 0;
      chk("err_start_ign", 32'(bus.State), 32'd7);
      chk("err_sticky", 32'(bus.Error), 32'd1);
      Reset_n = 0;
      #1;
      chk("err_rst_state", 32'(bus.State), 32'd0);
      chk("err_rst_error", 32'(bus.Error), 32'd0);
      clear_inputs();
      @(negedge Clk);
      Reset_n = 1;
      @(negedge Clk);

      // Five ALU instructions then halt at PC=5, restart
      pulse_start();
      alu = '{0, 1, 0, 0, 0, 10'h000, 0, 4, 1, 0, 0, 10'h000};
      for (int i = 0; i < 5; i++) run_instr(alu, lat, il, rw, rw_at, mr, mw, flg);
      chk("pre_halt_pc", 32'(bus.PC), 32'd5);
      bus.Halt_Instr = 1; bus.Write_Reg = 1; bus.Branch = 1; bus.Taken = 1;
      @(negedge Clk); @(negedge Clk);
      chk("halt_state", 32'(bus.State), 32'd6);
      chk("halt_done", 32'(bus.Done), 32'd1);
      chk("halt_pc", 32'(bus.PC), 32'd5);
      chk("halt_no_rw", 32'(bus.Reg_Write_En), 32'd0);
      clear_inputs();
      repeat (3) @(negedge Clk);
      chk("halt_done_hold", 32'(bus.Done), 32'd1);
      chk("halt_pc_hold", 32'(bus.PC), 32'd5);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_cycles", bus.Cycle_Cnt, 32'd22);
      chk("perf_instrs", bus.Instr_Cnt, 32'd5);
`endif
      pulse_start();
      chk("restart_state", 32'(bus.State), 32'd1);
      chk("restart_done", 32'(bus.Done), 32'd0);
      chk("restart_pc", 32'(bus.PC), 32'd0);
`ifdef SEQ_PERF_CNT_EN
      chk("perf_clr_cyc", bus.Cycle_Cnt, 32'd0);
      chk("perf_clr_ins", bus.Instr_Cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
